// File: rtl/fifo_pkg.sv
// Shared constants and gray-code helpers for both sides of the asynchronous FIFO.
package fifo_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 3;
  localparam int PTR_WIDTH  = ADDR_WIDTH + 1;
  localparam int FIFO_DEPTH = 1 << ADDR_WIDTH;

  function automatic logic [PTR_WIDTH-1:0] bin2gray(input logic [PTR_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all gray bits at or above it.
  function automatic logic [PTR_WIDTH-1:0] gray2bin(input logic [PTR_WIDTH-1:0] gray);
    logic [PTR_WIDTH-1:0] bin;
    bin[PTR_WIDTH-1] = gray[PTR_WIDTH-1];
    for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side FIFO bundle: write-pointer input, memory read port and downstream valid/ready stage.
interface fifo_rd_ctrl_if;
  import fifo_pkg::*;

  logic [PTR_WIDTH-1:0]  gray_wr_ptr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  dout_ready;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [PTR_WIDTH-1:0]  gray_rd_ptr;
  logic                  rd_empty;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic [PTR_WIDTH-1:0]  rd_level;

  // master is the read controller; slave is the surrounding FIFO and consumer.
  modport master (
    input  gray_wr_ptr, mem_rdata, dout_ready,
    output rd_addr, gray_rd_ptr, rd_empty, dout, dout_valid, rd_level
  );

  modport slave (
    output gray_wr_ptr, mem_rdata, dout_ready,
    input  rd_addr, gray_rd_ptr, rd_empty, dout, dout_valid, rd_level
  );

endinterface

// File: rtl/ptr_sync_2ff.sv
// Two-flop synchroniser for a gray-coded pointer crossing into the local clock domain.
module ptr_sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
    end
  end

  assign q = sync2;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the asynchronous FIFO: empty detection, read pointer and
// a registered valid/ready output stage sustaining one word per clock.
module fifo_rd_ctrl
  import fifo_pkg::*;
(
  input  logic          rd_clk,
  input  logic          rd_rst,
  fifo_rd_ctrl_if.master bus
);

  logic [PTR_WIDTH-1:0]  wsync2;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr_next;
  logic [PTR_WIDTH-1:0]  gray_rd_q;
  logic [PTR_WIDTH-1:0]  level_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  valid_q;
  logic                  empty;
  logic                  load;

  ptr_sync_2ff #(.WIDTH(PTR_WIDTH)) u_wr_sync (
    .rd_clk (rd_clk),
    .rd_rst (rd_rst),
    .d      (bus.gray_wr_ptr),
    .q      (wsync2)
  );

  // Pointers differing only in the top two gray bits mean full, which is still non-empty.
  always_comb begin
    empty       = (gray_rd_q == wsync2);
    load        = !empty && (!valid_q || bus.dout_ready);
    rd_ptr_next = load ? rd_ptr + 1'b1 : rd_ptr;
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rd_ptr    <= '0;
      gray_rd_q <= '0;
      level_q   <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      rd_ptr    <= rd_ptr_next;
      gray_rd_q <= bin2gray(rd_ptr_next);
      level_q   <= gray2bin(wsync2) - rd_ptr;
      if (load) begin
        dout_q  <= bus.mem_rdata;
        valid_q <= 1'b1;
      end else if (valid_q && bus.dout_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.rd_addr     = rd_ptr[ADDR_WIDTH-1:0];
  assign bus.gray_rd_ptr = gray_rd_q;
  assign bus.rd_empty    = empty;
  assign bus.dout        = dout_q;
  assign bus.dout_valid  = valid_q;
  assign bus.rd_level    = level_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: reset, single word, full burst, backpressure,
// pointer wrap and reset in the middle of a burst.
module tb_fifo_rd_ctrl;

  logic rd_clk = 1'b0;
  logic rd_rst = 1'b0;
  logic run    = 1'b0;
  int   tests  = 0;
  int   fails  = 0;

  logic [7:0] mem [8];
  logic [3:0] gseq [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  fifo_rd_ctrl_if bus ();

  fifo_rd_ctrl dut (
    .rd_clk (rd_clk),
    .rd_rst (rd_rst),
    .bus    (bus)
  );

  assign bus.mem_rdata = mem[bus.rd_addr];

  always begin
    #5;
    if (run) rd_clk = ~rd_clk;
  end

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_empty"}, 32'(bus.rd_empty), 32'd1);
    check_output({tag, "_valid"}, 32'(bus.dout_valid), 32'd0);
    check_output({tag, "_dout"}, 32'(bus.dout), 32'd0);
    check_output({tag, "_gray_rd"}, 32'(bus.gray_rd_ptr), 32'd0);
    check_output({tag, "_addr"}, 32'(bus.rd_addr), 32'd0);
    check_output({tag, "_level"}, 32'(bus.rd_level), 32'd0);
  endtask

  initial begin
    int wr;
    int rcv;
    int cyc;

    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    bus.gray_wr_ptr = 4'h0;
    bus.dout_ready  = 1'b0;

    // Asynchronous reset with the clock stopped
    #2 rd_rst = 1'b1;
    #1 check_reset_values("rst_async");
    rd_rst = 1'b0;
    run    = 1'b1;

    // Single word
    mem[0] = 8'hA5;
    bus.gray_wr_ptr = 4'h1;
    tick();
    check_output("single_empty_n", 32'(bus.rd_empty), 32'd1);
    tick();
    check_output("single_empty_n1", 32'(bus.rd_empty), 32'd0);
    check_output("single_valid_n1", 32'(bus.dout_valid), 32'd0);
    tick();
    check_output("single_dout", 32'(bus.dout), 32'hA5);
    check_output("single_valid", 32'(bus.dout_valid), 32'd1);
    check_output("single_gray_rd", 32'(bus.gray_rd_ptr), 32'h1);
    check_output("single_empty", 32'(bus.rd_empty), 32'd1);
    check_output("single_level", 32'(bus.rd_level), 32'd1);
    bus.dout_ready = 1'b1;
    tick();
    check_output("single_pop_valid", 32'(bus.dout_valid), 32'd0);
    check_output("single_pop_dout", 32'(bus.dout), 32'hA5);
    check_output("single_pop_level", 32'(bus.rd_level), 32'd0);

    // Full burst of eight words from a fresh reset
    bus.gray_wr_ptr = 4'h0;
    rd_rst = 1'b1;
    #1 rd_rst = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 8'(8'h10 + i);
    bus.gray_wr_ptr = 4'hC;
    tick();
    tick();
    check_output("burst_empty", 32'(bus.rd_empty), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_output("burst_dout", 32'(bus.dout), 32'(8'h10 + i));
      check_output("burst_valid", 32'(bus.dout_valid), 32'd1);
      check_output("burst_level", 32'(bus.rd_level), 32'(8 - i));
    end
    check_output("burst_gray_rd", 32'(bus.gray_rd_ptr), 32'hC);
    check_output("burst_empty_end", 32'(bus.rd_empty), 32'd1);
    tick();
    check_output("burst_valid_end", 32'(bus.dout_valid), 32'd0);
    check_output("burst_level_end", 32'(bus.rd_level), 32'd0);

    // Backpressure: three words, consumer stalled for five cycles
    bus.dout_ready = 1'b0;
    mem[0] = 8'h20;
    mem[1] = 8'h21;
    mem[2] = 8'h22;
    bus.gray_wr_ptr = gseq[11];
    tick();
    tick();
    tick();
    check_output("bp_first", 32'(bus.dout), 32'h20);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("bp_hold_dout", 32'(bus.dout), 32'h20);
      check_output("bp_hold_valid", 32'(bus.dout_valid), 32'd1);
      check_output("bp_hold_gray_rd", 32'(bus.gray_rd_ptr), 32'(gseq[9]));
      check_output("bp_hold_addr", 32'(bus.rd_addr), 32'd1);
    end
    bus.dout_ready = 1'b1;
    tick();
    check_output("bp_rel_dout1", 32'(bus.dout), 32'h21);
    tick();
    check_output("bp_rel_dout2", 32'(bus.dout), 32'h22);
    check_output("bp_rel_gray_rd", 32'(bus.gray_rd_ptr), 32'(gseq[11]));
    tick();
    check_output("bp_rel_valid", 32'(bus.dout_valid), 32'd0);
    check_output("bp_rel_empty", 32'(bus.rd_empty), 32'd1);

    // Wrap: twenty words with the writer kept ahead of the reader
    bus.gray_wr_ptr = 4'h0;
    rd_rst = 1'b1;
    #1 rd_rst = 1'b0;
    wr  = 0;
    rcv = 0;
    cyc = 0;
    while (rcv < 20 && cyc < 200) begin
      if (wr < rcv + 8 && wr < 24) begin
        mem[wr % 8] = 8'(8'h40 + wr);
        wr++;
        bus.gray_wr_ptr = gseq[wr % 16];
      end
      tick();
      cyc++;
      if (bus.dout_valid) begin
        check_output("wrap_dout", 32'(bus.dout), 32'(8'h40 + rcv));
        check_output("wrap_gray_rd", 32'(bus.gray_rd_ptr), 32'(gseq[(rcv + 1) % 16]));
        check_output("wrap_addr", 32'(bus.rd_addr), 32'((rcv + 1) % 8));
        rcv++;
      end
    end
    check_output("wrap_count", 32'(rcv), 32'd20);

    // Reset while a word is held and four more wait in memory
    bus.gray_wr_ptr = 4'h0;
    rd_rst = 1'b1;
    #1 rd_rst = 1'b0;
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) mem[i] = 8'(8'h50 + i);
    bus.gray_wr_ptr = gseq[5];
    tick();
    tick();
    tick();
    tick();
    check_output("mid_valid", 32'(bus.dout_valid), 32'd1);
    check_output("mid_level", 32'(bus.rd_level), 32'd4);
    check_output("mid_dout", 32'(bus.dout), 32'h50);
    #2;
    bus.gray_wr_ptr = 4'h0;
    rd_rst = 1'b1;
    #1 check_reset_values("mid_rst");
    rd_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("post_rst_empty", 32'(bus.rd_empty), 32'd1);
      check_output("post_rst_valid", 32'(bus.dout_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
